// File: rtl/keypad_scanner_pkg.sv
// Shared key-code constants and scanner state encoding for the safe-lock datapath.
package keypad_scanner_pkg;

    localparam int unsigned CODE_W    = 4;
    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 3;
    localparam int unsigned ROW_IDX_W = 2;

    // Codes shared with the seven-segment path and the lock controller
    localparam logic [CODE_W-1:0] KEY_DIGIT_MIN = 4'h0;
    localparam logic [CODE_W-1:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [CODE_W-1:0] KEY_STAR      = 4'hA;
    localparam logic [CODE_W-1:0] KEY_HASH      = 4'hB;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both stages reset to all ones.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with column synchronisation and press/release debounce.
// Optional build macro KEYPAD_MULTI_REJECT_EN rejects presses with several low columns.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CNT);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

    logic [2:0]           col_s;
    logic                 multi_low;
    logic                 cand_match;

    logic [1:0]           state_q,    state_d;
    logic [ROW_IDX_W-1:0] row_q,      row_d;
    logic [3:0]           row_n_q,    row_n_d;
    logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [DB_W-1:0]      db_cnt_q,   db_cnt_d;
    logic [ROW_IDX_W-1:0] cand_row_q, cand_row_d;
    logic [2:0]           cand_col_q, cand_col_d;
    logic [CODE_W-1:0]    key_code_q, key_code_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_held_q,  key_held_d;

    // Lowest-index low column of an active-low pattern
    function automatic logic [1:0] low_col(input logic [2:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else            return 2'd2;
    endfunction

    // Row/column to shared key code
    function automatic logic [CODE_W-1:0] key_map(input logic [1:0] r, input logic [1:0] c);
        if (r == 2'd3) begin
            case (c)
                2'd0:    return KEY_STAR;
                2'd1:    return KEY_DIGIT_MIN;
                default: return KEY_HASH;
            endcase
        end
        return CODE_W'({2'b00, r} * 4'd3 + {2'b00, c} + 4'd1);
    endfunction

    sync_2ff #(.WIDTH(3)) u_col_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (col_n),
        .q     (col_s)
    );

`ifdef KEYPAD_MULTI_REJECT_EN
    assign multi_low = ($countones(~col_s) > 1);
`else
    assign multi_low = 1'b0;
`endif

    assign cand_match = (col_s == cand_col_q) && !multi_low;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SCAN;
            row_q       <= '0;
            row_n_q     <= 4'b1110;
            scan_cnt_q  <= '0;
            db_cnt_q    <= '0;
            cand_row_q  <= '0;
            cand_col_q  <= 3'b111;
            key_code_q  <= KEY_DIGIT_MIN;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            row_n_q     <= row_n_d;
            scan_cnt_q  <= scan_cnt_d;
            db_cnt_q    <= db_cnt_d;
            cand_row_q  <= cand_row_d;
            cand_col_q  <= cand_col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        scan_cnt_d  = scan_cnt_q;
        db_cnt_d    = db_cnt_q;
        cand_row_d  = cand_row_q;
        cand_col_d  = cand_col_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        case (state_q)
            ST_SCAN: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (col_s == 3'b111 || multi_low) begin
                        row_d = row_q + ROW_IDX_W'(1);
                    end else begin
                        cand_row_d = row_q;
                        cand_col_d = col_s;
                        db_cnt_d   = '0;
                        state_d    = ST_PRESS_DB;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                end
            end
            ST_PRESS_DB: begin
                if (!cand_match) begin
                    row_d      = row_q + ROW_IDX_W'(1);
                    scan_cnt_d = '0;
                    state_d    = ST_SCAN;
                end else if (db_cnt_q == DB_LAST) begin
                    key_code_d  = key_map(cand_row_q, low_col(cand_col_q));
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = ST_HELD;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            ST_HELD: begin
                if (col_s == 3'b111) begin
                    db_cnt_d = '0;
                    state_d  = ST_REL_DB;
                end
            end
            ST_REL_DB: begin
                if (col_s != 3'b111) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    key_held_d = 1'b0;
                    row_d      = row_q + ROW_IDX_W'(1);
                    scan_cnt_d = '0;
                    state_d    = ST_SCAN;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = ST_SCAN;
        endcase

        // Exactly one row driven low, tracking the next row index
        row_n_d = ~(4'b0001 << row_d);
    end

    assign row_n     = row_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised and directed bench for keypad_scanner against a procedural keypad/scanner model.
module tb_keypad_scanner;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [11:0] pressed = '0;  // index = row*3 + col

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [3:0] last_code = 4'h0;

    // Model state
    int         m_row;
    int         m_db;
    bit         abort_f;
    logic [2:0] h1, h2;
    logic [3:0] exp_row_n, exp_code;
    logic       exp_valid, exp_held;
    logic [3:0] ktab [12] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                              4'h7, 4'h8, 4'h9, 4'hA, 4'h0, 4'hB};
    logic [3:0] walk [5]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Physical keypad: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
    end

    task automatic check(input string nm, input logic [3:0] act, input logic [3:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [2:0] raw_col(input int r);
        logic [2:0] c = 3'b111;
        for (int k = 0; k < 3; k++) if (pressed[r*3+k]) c[k] = 1'b0;
        return c;
    endfunction

    function automatic int lowest_low(input logic [2:0] c);
        for (int k = 0; k < 3; k++) if (!c[k]) return k;
        return 2;
    endfunction

    function automatic bit rejects(input logic [2:0] c);
`ifdef KEYPAD_MULTI_REJECT_EN
        return $countones(~c) > 1;
`else
        return (c == 3'b000) && 1'b0;
`endif
    endfunction

    task automatic set_row(input int r);
        m_row = r % 4;
        exp_row_n = 4'b1111;
        exp_row_n[m_row] = 1'b0;
    endtask

    // One clock edge: returns the synchronised column value the design acts on
    task automatic tick(output logic [2:0] cs);
        @(posedge clk);
        cs = h2;
        h2 = h1;
        h1 = raw_col(m_row);
        exp_valid = 1'b0;
        if (!rst_n) abort_f = 1'b1;
    endtask

    task automatic run_model();
        logic [2:0] cs, cand;
        bit ok, released;
        forever begin
            for (int i = 0; i < SD; i++) begin tick(cs); if (abort_f) return; end
            if (cs == 3'b111 || rejects(cs)) begin set_row(m_row + 1); continue; end
            cand = cs;
            ok = 1'b1;
            m_db = 0;
            for (int k = 1; k <= DB; k++) begin
                tick(cs); if (abort_f) return;
                if (cs != cand) begin ok = 1'b0; break; end
                m_db = k;
            end
            m_db = -1;
            if (!ok) begin set_row(m_row + 1); continue; end
            exp_code  = ktab[m_row*3 + lowest_low(cand)];
            exp_valid = 1'b1;
            exp_held  = 1'b1;
            released  = 1'b0;
            while (!released) begin
                do begin tick(cs); if (abort_f) return; end while (cs != 3'b111);
                released = 1'b1;
                for (int k = 0; k < DB; k++) begin
                    tick(cs); if (abort_f) return;
                    if (cs != 3'b111) begin released = 1'b0; break; end
                end
            end
            exp_held = 1'b0;
            set_row(m_row + 1);
        end
    endtask

    initial begin
        forever begin
            abort_f   = 1'b0;
            m_db      = -1;
            h1        = 3'b111;
            h2        = 3'b111;
            set_row(0);
            exp_code  = 4'h0;
            exp_valid = 1'b0;
            exp_held  = 1'b0;
            wait (rst_n === 1'b1);
            run_model();
            wait (rst_n === 1'b0);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            check("row_n", row_n, exp_row_n);
            check("key_code", key_code, exp_code);
            check("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
            check("key_held", {3'b000, key_held}, {3'b000, exp_held});
            if (key_valid) begin
                pulses++;
                last_code = key_code;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic hold_key(input int idx, input int n);
        pressed = '0;
        pressed[idx] = 1'b1;
        cyc(n);
        pressed = '0;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_row_n"}, row_n, 4'b1110);
        check({tag, "_code"}, key_code, 4'h0);
        check({tag, "_valid"}, {3'b000, key_valid}, 4'h0);
        check({tag, "_held"}, {3'b000, key_held}, 4'h0);
    endtask

    initial begin
        int p, n, idx, t;
        cyc(3);
        reset_values("rst");
        rst_n = 1'b1;

        for (int k = 1; k <= 16; k++) begin
            cyc(1);
            check("walk", row_n, walk[k/4]);
        end

        // Single press of key 5
        p = pulses;
        hold_key(4, 50);
        cyc(6);
        check("held_after_release", {3'b000, key_held}, 4'h1);
        cyc(10);
        check("held_cleared", {3'b000, key_held}, 4'h0);
        check_int("pulses_5", pulses - p, 1);
        check("code_5", last_code, 4'h5);
        cyc(10);

        // Symbol keys
        p = pulses;
        hold_key(9, 50); cyc(30);
        check("code_star", last_code, 4'hA);
        hold_key(11, 50); cyc(30);
        check("code_hash", last_code, 4'hB);
        check_int("pulses_sym", pulses - p, 2);

        // Press bounce on key 9
        p = pulses;
        for (int k = 0; k < 10; k++) begin
            pressed = '0;
            pressed[8] = (k % 2 == 0);
            cyc(3);
        end
        pressed = '0;
        cyc(30);
        check_int("pulses_bounce", pulses - p, 0);

        // Release bounce on key 4
        p = pulses;
        hold_key(3, 50); cyc(3);
        hold_key(3, 3);  cyc(3);
        hold_key(3, 20);
        check("held_rel_bounce", {3'b000, key_held}, 4'h1);
        cyc(30);
        check_int("pulses_rel_bounce", pulses - p, 1);
        check("code_4", last_code, 4'h4);

        // Reset at debounce count 5 with key 5 still held
        pressed = '0;
        pressed[4] = 1'b1;
        n = 0;
        while (m_db != 5 && n < 100) begin @(posedge clk); #1; n++; end
        check_int("db5_reached", (n < 100) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        reset_values("midrst");
        cyc(2);
        rst_n = 1'b1;
        p = pulses;
        cyc(40);
        check_int("pulses_after_rst", pulses - p, 1);
        check("code_after_rst", last_code, 4'h5);
        pressed = '0;
        cyc(30);

        // Keys 1 and 2 together
        p = pulses;
        pressed = '0;
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        cyc(50);
        pressed = '0;
        cyc(30);
`ifdef KEYPAD_MULTI_REJECT_EN
        check_int("pulses_multi", pulses - p, 0);
`else
        check_int("pulses_multi", pulses - p, 1);
        check("code_multi", last_code, 4'h1);
`endif

        // Random presses with optional bounce and second keys
        for (int it = 0; it < 16; it++) begin
            idx = $urandom_range(0, 11);
            t = $urandom_range(0, 4);
            for (int b = 0; b < t; b++) begin
                pressed = '0;
                pressed[idx] = (b % 2 == 0);
                cyc($urandom_range(1, 3));
            end
            pressed = '0;
            pressed[idx] = 1'b1;
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 11)] = 1'b1;
            cyc($urandom_range(5, 60));
            pressed = '0;
            cyc($urandom_range(5, 40));
        end
        cyc(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4×3 matrix keypad (0–9, `*`, `#`), synchronises and debounces the column inputs, and emits one 4-bit key code per debounced press. It is the input end of the safe-lock datapath. Its codes use the same 4-bit encoding that the seven-segment display path consumes: 0–9 → `4'h0`–`4'h9`, `*` → `4'hA`, `#` → `4'hB`. The lock controller consumes `key_valid`/`key_code`.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clock cycles each row is driven; minimum 4.
- `DEBOUNCE_CNT`, default 200000: consecutive stable cycles required for press and for release; minimum 2.

Ports (clock and reset first):
- `clk` in 1: single system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `col_n` in 3: keypad columns, active-low with external pull-ups, asynchronous to `clk`.
- `row_n` out 4: row drive, active-low, exactly one bit low at all times.
- `key_code` out 4: code of the last accepted key; held until the next accepted key.
- `key_valid` out 1: one-cycle pulse when a press is accepted.
- `key_held` out 1: high from the acceptance cycle until release is debounced.

## Operation
- Key map `[row][col]` (col 0 leftmost): row0 1 2 3; row1 4 5 6; row2 7 8 9; row3 `*` 0 `#`.
- `col_n` passes through a 2-flop synchroniser; the synchroniser flops reset to 1. All decisions use the synchronised value `col_s`.
- State machine:
  - **SCAN**: the dwell counter counts 0..`SCAN_DIV`-1. On terminal count with `col_s == 3'b111`, advance to the next row (3 wraps to 0) and clear the counter. On terminal count with any `col_s` bit low, latch the row and `col_s` as the candidate, hold the row, clear the debounce counter, and go to **PRESS_DB**.
  - **PRESS_DB**: row frozen. Each cycle with `col_s` equal to the candidate increments the counter. Any mismatch returns to SCAN at the next row. When the counter reaches `DEBOUNCE_CNT`-1 with a match: `key_code` ← mapped code, `key_valid` pulses, `key_held` ← 1, go to **HELD**.
  - **HELD**: row frozen. `col_s == 3'b111` clears the counter and goes to **REL_DB**.
  - **REL_DB**: counts cycles with `col_s == 3'b111`. Any low bit returns to HELD with no new pulse. At `DEBOUNCE_CNT`-1: `key_held` ← 0, go to SCAN at the next row.
- Multiple low columns in one row, default build: the lowest-index low column wins; the candidate pattern must still remain stable through PRESS_DB.
- A different key pressed while in HELD is ignored until the full release is debounced.

## Timing
- Reset values: `row_n = 4'b1110`, `key_code = 4'h0`, `key_valid = 0`, `key_held = 0`, state SCAN, all counters 0.
- Reset may be asserted in any state and fully aborts the operation in progress; no `key_valid` pulse is produced afterwards for a press that was pending.
- Input-to-`col_s` latency is 2 cycles. `SCAN_DIV >= 4` guarantees that the terminal-count sample reflects the currently driven row.
- Press latency: `key_valid` rises `DEBOUNCE_CNT` cycles after the SCAN terminal-count sample, given a stable input. `key_code` changes in the same cycle.
- Counter widths are `$clog2` of the parameter; counters saturate and never wrap.

## Configuration
- `KEYPAD_MULTI_REJECT_EN`:
  - Defined: a candidate with more than one low `col_s` bit is rejected and SCAN advances normally. During PRESS_DB, a second low column also counts as a mismatch.
  - Undefined: lowest-index-column-wins behaviour as described in Operation.

## Structure
- Key-code constants (`KEY_STAR = 4'hA`, `KEY_HASH = 4'hB`, digit range) go in the shared team parameter header so that the display and lock controller use identical codes.
- Sub-module `sync_2ff` (parameterised width, reset value 1) holds the column synchroniser.
- Row and column to code mapping is a combinational function inside the block.

## Test plan
Benches run with `SCAN_DIV = 4` and `DEBOUNCE_CNT = 8`.
- **Reset:** check the reset values. Release reset → `row_n` walks 1110 → 1101 → 1011 → 0111 → 1110, every 4 cycles.
- **Single press:** hold key 5 (row1, col1) for 50 cycles → exactly one `key_valid` with `key_code = 4'h5`; `key_held` stays 1 until 8 cycles after release.
- **Symbol keys:** press `*` → code `4'hA`; release; press `#` → code `4'hB`. One pulse each.
- **Bounce:** key 9 toggles every 3 cycles for 30 cycles, then releases → no `key_valid`. Release bounce shorter than 8 cycles while held → `key_held` stays 1 with no second pulse.
- **Reset mid-debounce:** assert `rst_n = 0` at debounce count 5 → outputs return to reset values at once; key still held after reset → a fresh full debounce, then one pulse.
- **Multi-key:** keys 1 and 2 held together → default build: code `4'h1`; with `KEYPAD_MULTI_REJECT_EN`: no `key_valid`.
